// File: rtl/skl8_seq_adder_if.sv
// skl8_seq_adder_if
//   Request/result bundle for skl8_seq_adder.
//   Two request channels (req0_*, req1_*): valid/ready handshake, operands a/b,
//   carry-in, and a subtract select that exists only when SKL8_SEQ_SUB_EN is
//   defined. One result channel (res_*): valid/ready, WIDTH-bit sum, carry-out
//   and the id of the owning requester.
//   Modports: master = requesters + result consumer, slave = the adder.
interface skl8_seq_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
`ifdef SKL8_SEQ_SUB_EN
  logic             req0_sub;
  logic             req1_sub;
`endif
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
`ifdef SKL8_SEQ_SUB_EN
    output req0_sub, req1_sub,
`endif
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
`ifdef SKL8_SEQ_SUB_EN
    input  req0_sub, req1_sub,
`endif
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready
  );
endinterface

// File: rtl/skl8_seq_adder.sv
// skl8_seq_adder
//   Time-shared WIDTH-bit adder. Two requesters are round-robin arbitrated onto
//   one 8-bit Sklansky prefix slice (skl8); each accepted operation is summed
//   one byte per cycle, LSB byte first, carry held in a register between bytes.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - skl8_seq_adder_if.slave: req0_*/req1_* requests, res_* result
//   Optional feature: define SKL8_SEQ_SUB_EN to add reqN_sub (a - b mode).

// skl8: 8-bit Sklansky prefix adder slice.
//   a_i, b_i  - operand bytes      cin_i   - carry in
//   s_o       - sum byte           cout_o  - carry out of bit 7
//   p_out_o   - group propagate    g_out_o - group generate (bits 7:0)
module skl8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o,
  output logic       p_out_o,
  output logic       g_out_o
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  assign g0 = a_i & b_i;
  assign p0 = a_i ^ b_i;

  // Level 1: span 2, odd bits combine with their lower neighbour.
  for (genvar i = 0; i < 8; i++) begin : g_l1
    if (i % 2 == 1) begin : g_cmb
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
      assign p1[i] = p0[i] & p0[i-1];
    end else begin : g_pass
      assign g1[i] = g0[i];
      assign p1[i] = p0[i];
    end
  end

  // Level 2: span 4, upper half of each nibble combines with that nibble's bit 1.
  for (genvar i = 0; i < 8; i++) begin : g_l2
    if ((i / 2) % 2 == 1) begin : g_cmb
      assign g2[i] = g1[i] | (p1[i] & g1[(i/4)*4+1]);
      assign p2[i] = p1[i] & p1[(i/4)*4+1];
    end else begin : g_pass
      assign g2[i] = g1[i];
      assign p2[i] = p1[i];
    end
  end

  // Level 3: span 8, upper nibble combines with bit 3.
  for (genvar i = 0; i < 8; i++) begin : g_l3
    if (i >= 4) begin : g_cmb
      assign g3[i] = g2[i] | (p2[i] & g2[3]);
      assign p3[i] = p2[i] & p2[3];
    end else begin : g_pass
      assign g3[i] = g2[i];
      assign p3[i] = p2[i];
    end
  end

  // g3/p3 hold group terms for bits [i:0]; cin folds in as bit -1.
  assign c       = {g3 | (p3 & {8{cin_i}}), cin_i};
  assign s_o     = p0 ^ c[7:0];
  assign cout_o  = c[8];
  assign p_out_o = p3[7];
  assign g_out_o = g3[7];
endmodule

module skl8_seq_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  skl8_seq_adder_if.slave  bus
);
  localparam int unsigned   NBYTES = WIDTH / 8;
  localparam int unsigned   KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             prio_q, prio_d;
  logic [KW-1:0]    k_q, k_d;

  logic             gnt_any, gnt_id;
  logic [7:0]       sl_a, sl_b, sl_s;
  logic             sl_cin, sl_cout;
  logic             slice_p_unused, slice_g_unused;
`ifdef SKL8_SEQ_SUB_EN
  logic             sel_sub;
`endif

  // Arbitration: a lone requester wins; on contention prio_q picks.
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
  end

`ifdef SKL8_SEQ_SUB_EN
  assign sel_sub = gnt_id ? bus.req1_sub : bus.req0_sub;
`endif

  // Byte k of the latched operands feeds the shared slice.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == i[KW-1:0]) begin
        sl_a = a_q[i*8 +: 8];
        sl_b = b_q[i*8 +: 8];
      end
    end
    sl_cin = (k_q == '0) ? cin_q : carry_q;
  end

  // Group p/g are only useful when slices are chained; carry ripples via carry_q.
  skl8 u_slice (
    .a_i     (sl_a),
    .b_i     (sl_b),
    .cin_i   (sl_cin),
    .s_o     (sl_s),
    .cout_o  (sl_cout),
    .p_out_o (slice_p_unused),
    .g_out_o (slice_g_unused)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any)       state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req0_ready = ~rst & (state_q == IDLE) & gnt_any & ~gnt_id;
    bus.req1_ready = ~rst & (state_q == IDLE) & gnt_any &  gnt_id;
    bus.res_valid  = (state_q == DONE);
    bus.res_sum    = sum_q;
    bus.res_cout   = cout_q;
    bus.res_id     = id_q;
  end

  // Datapath next state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    id_d    = id_q;
    prio_d  = prio_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = gnt_id ? bus.req1_a : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b : bus.req0_b;
          cin_d   = gnt_id ? bus.req1_cin : bus.req0_cin;
`ifdef SKL8_SEQ_SUB_EN
          // a - b as a + ~b + 1
          if (sel_sub) begin
            b_d   = ~(gnt_id ? bus.req1_b : bus.req0_b);
            cin_d = 1'b1;
          end
`endif
          id_d    = gnt_id;
          k_d     = '0;
          carry_d = 1'b0;
          prio_d  = ~gnt_id;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (k_q == i[KW-1:0]) sum_d[i*8 +: 8] = sl_s;
        end
        carry_d = sl_cout;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) cout_d = sl_cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      k_q     <= k_d;
    end
  end
endmodule

// File: tb/tb_skl8_seq_adder.sv
// tb_skl8_seq_adder
//   Scoreboard bench for skl8_seq_adder: requests are recorded when accepted,
//   the expected result is queued from an arithmetic reference, and a monitor
//   compares each result presented on the res_* channel.
module tb_skl8_seq_adder;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NBYTES = WIDTH / 8;

  logic clk = 1'b0;
  logic rst;

  skl8_seq_adder_if #(.WIDTH(WIDTH)) bus();

  skl8_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
    int unsigned      acc_cyc;
  } exp_t;

  exp_t             sb[$];
  logic             gnt_log[$];
  int unsigned      tests = 0;
  int unsigned      fails = 0;
  int unsigned      cyc   = 0;
  int unsigned      rr_mode = 1;   // 0: res_ready low, 1: high, 2: random
  logic             prio_m  = 1'b0;
  logic             busy    = 1'b0;
  logic             holding = 1'b0;
  logic [WIDTH-1:0] held_sum, last_sum;
  logic             held_cout, held_id, last_cout, last_id;
  int unsigned      last_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic id,
                                 input int unsigned c);
    exp_t e;
    longint unsigned full;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      full   = longint'(a) + longint'(b) + longint'(cin);
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
    end
    e.id      = id;
    e.acc_cyc = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.res_ready = 1'b0;
      1:       bus.res_ready = 1'b1;
      default: bus.res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: accepts and results, sampled on the falling edge.
  always @(negedge clk) begin
    logic g, sub_s;
    exp_t e;
    if (rst) begin
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_res_sum", bus.res_sum, 0);
      chk("rst_res_cout", bus.res_cout, 0);
      chk("rst_res_id", bus.res_id, 0);
      sb.delete();
      prio_m  = 1'b0;
      busy    = 1'b0;
      holding = 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        chk("single_ready", bus.req0_ready & bus.req1_ready, 0);
        chk("ready_while_busy", busy, 0);
        chk("ready_has_valid", g ? bus.req1_valid : bus.req0_valid, 1);
        chk("grant_id", g, (bus.req0_valid && bus.req1_valid) ? prio_m : bus.req1_valid);
        sub_s = 1'b0;
`ifdef SKL8_SEQ_SUB_EN
        sub_s = g ? bus.req1_sub : bus.req0_sub;
`endif
        if (g) sb.push_back(model(bus.req1_a, bus.req1_b, bus.req1_cin, sub_s, 1'b1, cyc));
        else   sb.push_back(model(bus.req0_a, bus.req0_b, bus.req0_cin, sub_s, 1'b0, cyc));
        gnt_log.push_back(g);
        prio_m = ~g;
        busy   = 1'b1;
      end
      if (bus.res_valid) begin
        if (!holding) begin
          chk("result_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("res_sum", bus.res_sum, e.sum);
            chk("res_cout", bus.res_cout, e.cout);
            chk("res_id", bus.res_id, e.id);
            last_lat = cyc - e.acc_cyc;
            chk("latency", last_lat, NBYTES + 1);
          end
          held_sum  = bus.res_sum;
          held_cout = bus.res_cout;
          held_id   = bus.res_id;
          last_sum  = bus.res_sum;
          last_cout = bus.res_cout;
          last_id   = bus.res_id;
          holding   = 1'b1;
        end else begin
          chk("hold_sum", bus.res_sum, held_sum);
          chk("hold_cout", bus.res_cout, held_cout);
          chk("hold_id", bus.res_id, held_id);
        end
        if (bus.res_ready) begin
          holding = 1'b0;
          busy    = 1'b0;
        end
      end else if (holding) begin
        chk("res_valid_dropped", 1, 0);
        holding = 1'b0;
        busy    = 1'b0;
      end
    end
  end

  function automatic logic [WIDTH-1:0] rnd();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(WIDTH-1){1'b0}}};
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    if (id == 1'b0) begin
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_cin   = cin;
`ifdef SKL8_SEQ_SUB_EN
      bus.req0_sub   = sub;
`endif
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_cin   = cin;
`ifdef SKL8_SEQ_SUB_EN
      bus.req1_sub   = sub;
`endif
      bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input logic id);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (!rst && (id ? bus.req1_ready : bus.req0_ready)) got = 1;
    end
    chk(id ? "accept_req1" : "accept_req0", got, 1);
  endtask

  task automatic drop(input logic id);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic send(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    drive(id, a, b, cin, sub);
    wait_accept(id);
    @(posedge clk);
    #1;
    drop(id);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    chk("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  // Both requesters kept valid back to back; operands refresh after each accept.
  task automatic alt_loop(input logic id, input int n);
    for (int i = 0; i < n; i++) begin
      drive(id, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_accept(id);
      @(posedge clk);
      #1;
    end
    drop(id);
  endtask

  task automatic rnd_loop(input logic id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(id, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
`ifdef SKL8_SEQ_SUB_EN
    bus.req0_sub = 1'b0;
    bus.req1_sub = 1'b0;
`endif
    bus.res_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Carry across byte 0 -> byte 1
    send(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_drain();
    chk("t1_sum", last_sum, 32'h0000_0100);
    chk("t1_cout", last_cout, 0);
    chk("t1_id", last_id, 0);
    chk("t1_latency", last_lat, 5);

    // Carry rippling through all bytes
    send(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_drain();
    chk("t2_sum", last_sum, 32'h0000_0000);
    chk("t2_cout", last_cout, 1);
    chk("t2_id", last_id, 1);

    // Consumer stall in DONE with a competing request waiting
    rr_mode = 0;
    send(1'b0, rnd(), rnd(), 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1;
    end
    chk("stall_res_valid_seen", seen, 1);
    @(posedge clk);
    #1 drive(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_res_valid", bus.res_valid, 1);
      chk("stall_req0_ready", bus.req0_ready, 0);
      chk("stall_req1_ready", bus.req1_ready, 0);
    end
    rr_mode = 1;
    wait_accept(1'b1);
    @(posedge clk);
    #1 drop(1'b1);
    wait_drain();
    chk("stall_next_id", last_id, 1);

    // Both valid from reset: grants alternate starting at 0
    rst = 1'b1;
    gnt_log.delete();
    fork
      alt_loop(1'b0, 4);
      alt_loop(1'b1, 4);
      begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    wait_drain();
    chk("alt_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("alt_grant", gnt_log[i], 64'(i % 2));

    // Reset during the second RUN cycle discards the operation and prio
    drive(1'b0, rnd(), rnd(), 1'b0, 1'b0);
    wait_accept(1'b0);
    @(posedge clk);
    #1 drop(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrun_rst_valid", bus.res_valid, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    gnt_log.delete();
    fork
      send(1'b1, rnd(), rnd(), 1'b1, 1'b0);
      send(1'b0, rnd(), rnd(), 1'b0, 1'b0);
    join
    wait_drain();
    chk("post_rst_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("post_rst_first", gnt_log[0], 0);
      chk("post_rst_second", gnt_log[1], 1);
    end

    // Random traffic with random consumer back-pressure
    rr_mode = 2;
    fork
      rnd_loop(1'b0, 12);
      rnd_loop(1'b1, 12);
    join
    wait_drain();
    rr_mode = 1;

`ifdef SKL8_SEQ_SUB_EN
    send(1'b0, 32'd5, 32'd7, 1'b0, 1'b1);
    wait_drain();
    chk("sub_neg_sum", last_sum, 32'hFFFF_FFFE);
    chk("sub_neg_cout", last_cout, 0);
    send(1'b1, 32'd7, 32'd5, 1'b0, 1'b1);
    wait_drain();
    chk("sub_pos_sum", last_sum, 32'h0000_0002);
    chk("sub_pos_cout", last_cout, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/skl8_seq_adder.md
# skl8_seq_adder

Time-shared wide adder controller. Two requesters share one `skl8` 8-bit prefix-adder slice through a round-robin arbiter. Each granted WIDTH-bit addition is sequenced byte-serially, least-significant byte first, with the carry held in a register between bytes. Results return on a valid/ready port tagged with the requester id.

## Interface
- `WIDTH`, default 32: operand width; a multiple of 8 and ≥ 8. NBYTES = WIDTH/8.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_cin` / `req1_cin`  in  1  carry-in.
- `req0_sub` / `req1_sub`  in  1  subtract select; present only with `SKL8_SEQ_SUB_EN`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  WIDTH  sum.
- `res_cout`  out  1  carry-out of bit WIDTH-1.
- `res_id`  out  1  index of the requester that owns the result.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Requests transfer when `reqN_valid && reqN_ready`.
- IDLE arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the priority pointer `prio` is granted. `prio` resets to 0.
- IDLE, on a grant:
  - `reqN_ready` = 1 for the granted requester only, combinationally.
  - Latch a, b, cin and id; clear byte index k and the carry register.
  - `prio` ← the other requester (not the granted one).
  - Next state is RUN.
- IDLE, with no request valid: stay in IDLE.
- `reqN_ready` is 0 in RUN and DONE. While `rst` is high, both `reqN_ready` are 0.
- RUN, one byte per cycle:
  - The slice receives a[8k+7:8k], b[8k+7:8k], and the carry (the latched cin when k = 0).
  - Slice `s` is written to sum[8k+7:8k]; carry ← slice `cout`; k ← k+1.
  - When k = NBYTES-1 the next state is DONE and the final `cout` is stored to `res_cout`.
  - The slice's `p_out` and `g_out` are left unconnected.
- DONE:
  - `res_valid` = 1; `res_sum`, `res_cout` and `res_id` are held stable.
  - On `res_ready` = 1 the next state is IDLE.
  - With `res_ready` held low, DONE holds indefinitely. No new request is accepted during this time.
- Arithmetic: `res_sum` = (a + b + cin) mod 2^WIDTH. `res_cout` is bit WIDTH of the full sum. No overflow flag is produced.

## Timing
- Accept at edge T. The RUN bytes occupy edges T+1 … T+NBYTES.
- `res_valid` rises after edge T+NBYTES, i.e. NBYTES+1 cycles after accept. For WIDTH = 32 that is 5 cycles.
- Minimum spacing between accepts is NBYTES+2 cycles: one DONE cycle plus one IDLE cycle.
- Output reset values: `res_valid` = 0, `res_sum` = 0, `res_cout` = 0, `res_id` = 0, both `reqN_ready` = 0.
- `rst` asserted at any point, including mid-RUN or during DONE:
  - Outputs return to their reset values immediately.
  - The in-flight operation is discarded.
  - `prio` returns to 0.
  - No result is ever emitted for the discarded operation.
- `res_sum` and `res_cout` are valid only while `res_valid` = 1. Outside DONE they show the partial register contents.

## Configuration
- `SKL8_SEQ_SUB_EN` defined:
  - The `req0_sub` and `req1_sub` ports exist.
  - sub = 1 latches ~b and forces the carry-in to 1, ignoring `reqN_cin`. The result is a − b mod 2^WIDTH.
  - In subtract mode, `res_cout` = 1 means no borrow.
  - sub = 0 behaves as plain add.
- `SKL8_SEQ_SUB_EN` undefined: the sub ports are absent and every operation is an add.

## Test plan
- WIDTH = 32; req0 a=0x000000FF, b=0x00000001, cin=0 -> `res_sum`=0x00000100, `res_cout`=0, `res_id`=0, `res_valid` exactly 5 cycles after accept.
- req1 a=0xFFFFFFFF, b=0x00000000, cin=1 -> `res_sum`=0x00000000, `res_cout`=1, `res_id`=1. This exercises the carry chain across all 4 bytes.
- Both requesters held valid from reset with `res_ready` = 1 -> grants alternate 0,1,0,1. Each accepted result matches its own operands.
- `res_ready` low for 3 cycles in DONE -> `res_valid`, `res_sum` and `res_id` stay stable, and both `reqN_ready` stay 0. Result transfers on the cycle `res_ready` = 1.
- `rst` pulsed at the 2nd RUN cycle -> `res_valid` = 0 with no result emitted. After release, req1 then req0 are both valid; req0 is granted first because `prio` = 0.
- `SKL8_SEQ_SUB_EN`:
  - a=5, b=7, sub=1 -> `res_sum`=0xFFFFFFFE, `res_cout`=0.
  - a=7, b=5, sub=1 -> `res_sum`=0x00000002, `res_cout`=1.
